program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction memory: the 16-bit CPU controller reads instruction memory during phase 1; this block writes program words into it from the board's 4-bit nibble switches.
- Assembles four nibbles, MSB-first, into one 16-bit word and issues a one-cycle write at an auto-incrementing address.
- Holds the CPU off (cpuHold) for the whole load session.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width; capacity DEPTH = 2^ADDR_WIDTH words.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  rising edge opens a load session.
- strobe  input  1  rising edge enters the nibble on `in`.
- finish  input  1  rising edge closes the session.
- in  input  4  nibble value, sampled on a strobe edge.
- imAddress  output  ADDR_WIDTH  instruction memory write address.
- imData  output  16  instruction memory write data.
- imWren  output  1  instruction memory write enable, one cycle per word.
- cpuHold  output  1  high while a session is open; the controller must not exec.
- outDone  output  1  one-cycle pulse when a session ends.
- wordCount  output  ADDR_WIDTH+1  words written in the current or last session.
- overflow  output  1  sticky; a nibble arrived while memory was full.
- outState  output  2  FSM state, for debug display.

Behaviour:
- Edge detect: each of start, strobe and finish has a prev register. Edge = input & ~prev. The prev registers reset to 1, so a line held high through reset produces no edge.
- All outputs are registered. Reset values: imAddress 0, imData 0, imWren 0, cpuHold 0, outDone 0, wordCount 0, overflow 0, outState IDLE.
- States: IDLE=00, COLLECT=01, WRITE=10, DONE=11.
- IDLE:
  - cpuHold=0.
  - start edge -> COLLECT. Also clears address, wordCount, overflow, nibble counter and shift register; cpuHold=1 from the next cycle.
  - strobe and finish edges are ignored.
- COLLECT:
  - strobe edge: shift <= {shift[11:0], in}; nibCnt++.
  - When the 4th nibble enters (nibCnt==3) -> WRITE.
  - start edge is ignored.
- WRITE (exactly one cycle):
  - imWren=1, imData=assembled word, imAddress=current address.
  - Next cycle: imWren=0, address+1, wordCount+1, nibCnt=0.
  - Write latency: the 4th strobe edge is detected at cycle N; imWren is high during cycle N+1.
  - Go to COLLECT, or to DONE if the session is ending (see below).
- Strobe edge during WRITE: accepted as nibble 0 of the next word (shift <= {12'b0, in}, nibCnt=1). It is not lost.
- Finish edge:
  - In COLLECT: any partial word (nibCnt != 0) is discarded, with no write -> DONE.
  - In WRITE: the write completes -> DONE.
- Finish and strobe edges in the same COLLECT cycle: the nibble is processed first.
  - If it completes a word: WRITE, then DONE.
  - Otherwise: the partial word is discarded -> DONE.
- Full memory:
  - When wordCount reaches DEPTH after a write, the address wraps to 0 but no further writes occur.
  - Any later strobe edge in COLLECT sets overflow=1 and is otherwise ignored.
  - The session stays open until finish.
- DONE (one cycle): outDone=1, cpuHold=1 -> IDLE. cpuHold falls on the following cycle.
- wordCount and overflow hold their values in IDLE until the next start edge.
- Reset mid-session:
  - FSM -> IDLE on the next posedge; imWren and cpuHold go low.
  - The partial word is discarded.
  - Words already written remain in memory.

Test Plan:
1. Reset, start edge, then strobes with in=1,2,3,4 -> one cycle with imWren=1, imAddress=0, imData=16'h1234; wordCount=1; cpuHold=1 throughout.
2. Eight nibbles A,B,C,D,0,0,0,F, then finish -> writes 16'hABCD at address 0 and 16'h000F at address 1; outDone pulses once; cpuHold falls the cycle after DONE.
3. Nibbles 1,2 then finish -> no imWren; wordCount=0; outDone=1; session ends in IDLE.
4. 4th strobe edge, then the next strobe (in=7) arriving in the WRITE cycle -> word written, nibCnt=1, and the next word begins 0x7___ (e.g. 7,8,9,A -> 16'h789A at address 1).
5. ADDR_WIDTH=2: write 4 words, then another strobe -> overflow=1, no fifth imWren, wordCount=4; a subsequent start clears overflow.
6. Reset asserted after 2 nibbles, and separately a strobe held high through reset -> FSM IDLE, imWren=0, cpuHold=0; no spurious nibble captured after reset release.

Source files
------------

// File: rtl/program_loader_if.sv
// Bus between the program loader and its surroundings: board controls in,
// instruction-memory write port and session status out.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  strobe;
  logic                  finish;
  logic [3:0]            in;
  logic [ADDR_WIDTH-1:0] imAddress;
  logic [15:0]           imData;
  logic                  imWren;
  logic                  cpuHold;
  logic                  outDone;
  logic [ADDR_WIDTH:0]   wordCount;
  logic                  overflow;
  logic [1:0]            outState;

  modport master (
    input  start, strobe, finish, in,
    output imAddress, imData, imWren, cpuHold, outDone, wordCount, overflow, outState
  );

  modport slave (
    output start, strobe, finish, in,
    input  imAddress, imData, imWren, cpuHold, outDone, wordCount, overflow, outState
  );
endinterface

// File: rtl/program_loader.sv
// Instruction-memory writer: packs four switch nibbles (MSB first) into a
// 16-bit word and writes it at an auto-incrementing address, holding the CPU.
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input logic              clock,
  input logic              reset,
  program_loader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    WRITE   = 2'b10,
    DONE    = 2'b11
  } state_e;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic                  start_prev_q, strobe_prev_q, finish_prev_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  wren_q, wren_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            nib_q, nib_d;
  logic [11:0]           shift_q, shift_d;
  logic                  pend_q, pend_d;

  logic start_e, strobe_e, finish_e, full;

  assign start_e  = bus.start  & ~start_prev_q;
  assign strobe_e = bus.strobe & ~strobe_prev_q;
  assign finish_e = bus.finish & ~finish_prev_q;
  assign full     = (count_q == FULL_COUNT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    nib_d   = nib_q;
    shift_d = shift_q;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        if (start_e) begin
          state_d = COLLECT;
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          nib_d   = '0;
          shift_d = '0;
          pend_d  = 1'b0;
        end
      end
      COLLECT: begin
        // The nibble is handled before finish so a completing nibble still gets written.
        if (strobe_e) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            shift_d = {shift_q[7:0], bus.in};
            nib_d   = nib_q + 2'd1;
            if (nib_q == 2'd3) begin
              data_d  = {shift_q, bus.in};
              state_d = WRITE;
              pend_d  = finish_e;
            end
          end
        end
        if (finish_e && (state_d != WRITE)) begin
          state_d = DONE;
          nib_d   = '0;
          shift_d = '0;
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        count_d = count_q + (ADDR_WIDTH+1)'(1);
        nib_d   = '0;
        if (strobe_e) begin
          shift_d = {8'b0, bus.in};
          nib_d   = 2'd1;
        end
        state_d = (finish_e || pend_q) ? DONE : COLLECT;
        pend_d  = 1'b0;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    wren_d = (state_d == WRITE);
    hold_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      start_prev_q  <= 1'b1;
      strobe_prev_q <= 1'b1;
      finish_prev_q <= 1'b1;
      addr_q        <= '0;
      data_q        <= '0;
      wren_q        <= 1'b0;
      hold_q        <= 1'b0;
      done_q        <= 1'b0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      nib_q         <= '0;
      shift_q       <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= bus.start;
      strobe_prev_q <= bus.strobe;
      finish_prev_q <= bus.finish;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wren_q        <= wren_d;
      hold_q        <= hold_d;
      done_q        <= done_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      nib_q         <= nib_d;
      shift_q       <= shift_d;
      pend_q        <= pend_d;
    end
  end

  assign bus.imAddress = addr_q;
  assign bus.imData    = data_q;
  assign bus.imWren    = wren_q;
  assign bus.cpuHold   = hold_q;
  assign bus.outDone   = done_q;
  assign bus.wordCount = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.outState  = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: one default-width instance and one
// with ADDR_WIDTH=2 for the full-memory case.
module tb_program_loader;

  typedef struct { int unsigned addr; int unsigned data; } wr_t;
  typedef struct { int unsigned cnt;  int unsigned ovf;  } dn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_r = 1'b0, strobe_r = 1'b0, finish_r = 1'b0;
  logic [3:0] in_r = '0;
  int unsigned sel = 0;

  int tests = 0;
  int fails = 0;

  wr_t wq1[$], wq2[$];
  dn_t dq1[$], dq2[$];

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(8)) if1 ();
  program_loader_if #(.ADDR_WIDTH(2)) if2 ();

  assign if1.start  = start_r  & (sel == 0);
  assign if1.strobe = strobe_r & (sel == 0);
  assign if1.finish = finish_r & (sel == 0);
  assign if1.in     = in_r;
  assign if2.start  = start_r  & (sel == 1);
  assign if2.strobe = strobe_r & (sel == 1);
  assign if2.finish = finish_r & (sel == 1);
  assign if2.in     = in_r;

  program_loader #(.ADDR_WIDTH(8)) dut1 (.clock(clk), .reset(reset), .bus(if1));
  program_loader #(.ADDR_WIDTH(2)) dut2 (.clock(clk), .reset(reset), .bus(if2));

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a write or a done pulse.
  wr_t w1, w2;
  dn_t d1, d2;
  always @(negedge clk) begin
    if (!reset) begin
      if (if1.imWren) begin
        if (wq1.size() == 0) chk("dut1 unexpected write addr", 32'(if1.imAddress), 32'hFFFF_FFFF);
        else begin
          w1 = wq1.pop_front();
          chk("dut1 write addr", 32'(if1.imAddress), w1.addr);
          chk("dut1 write data", 32'(if1.imData), w1.data);
        end
      end
      if (if1.outDone) begin
        if (dq1.size() == 0) chk("dut1 unexpected done", 32'(if1.wordCount), 32'hFFFF_FFFF);
        else begin
          d1 = dq1.pop_front();
          chk("dut1 done wordCount", 32'(if1.wordCount), d1.cnt);
          chk("dut1 done overflow", 32'(if1.overflow), d1.ovf);
          chk("dut1 done cpuHold", 32'(if1.cpuHold), 1);
        end
      end
      if (if2.imWren) begin
        if (wq2.size() == 0) chk("dut2 unexpected write addr", 32'(if2.imAddress), 32'hFFFF_FFFF);
        else begin
          w2 = wq2.pop_front();
          chk("dut2 write addr", 32'(if2.imAddress), w2.addr);
          chk("dut2 write data", 32'(if2.imData), w2.data);
        end
      end
      if (if2.outDone) begin
        if (dq2.size() == 0) chk("dut2 unexpected done", 32'(if2.wordCount), 32'hFFFF_FFFF);
        else begin
          d2 = dq2.pop_front();
          chk("dut2 done wordCount", 32'(if2.wordCount), d2.cnt);
          chk("dut2 done overflow", 32'(if2.overflow), d2.ovf);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_w(input int unsigned a, input int unsigned d);
    wr_t w;
    w.addr = a; w.data = d;
    if (sel == 0) wq1.push_back(w); else wq2.push_back(w);
  endtask

  task automatic push_d(input int unsigned c, input int unsigned o);
    dn_t d;
    d.cnt = c; d.ovf = o;
    if (sel == 0) dq1.push_back(d); else dq2.push_back(d);
  endtask

  task automatic nib(input logic [3:0] v);
    in_r = v; strobe_r = 1'b1; tick(1);
    strobe_r = 1'b0; tick(1);
  endtask

  task automatic start_pulse();
    start_r = 1'b1; tick(1);
    start_r = 1'b0; tick(1);
  endtask

  task automatic fin_pulse();
    finish_r = 1'b1; tick(1);
    finish_r = 1'b0; tick(1);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst imAddress", 32'(if1.imAddress), 0);
    chk("rst imData", 32'(if1.imData), 0);
    chk("rst imWren", 32'(if1.imWren), 0);
    chk("rst cpuHold", 32'(if1.cpuHold), 0);
    chk("rst outDone", 32'(if1.outDone), 0);
    chk("rst wordCount", 32'(if1.wordCount), 0);
    chk("rst overflow", 32'(if1.overflow), 0);
    chk("rst outState", 32'(if1.outState), 0);
    chk("rst dut2 outState", 32'(if2.outState), 0);
    reset = 1'b0;
    tick(1);

    // 1: single word 1234
    start_pulse();
    chk("t1 cpuHold after start", 32'(if1.cpuHold), 1);
    chk("t1 state COLLECT", 32'(if1.outState), 1);
    push_w(0, 16'h1234);
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    chk("t1 wordCount", 32'(if1.wordCount), 1);
    chk("t1 cpuHold held", 32'(if1.cpuHold), 1);
    push_d(1, 0);
    finish_r = 1'b1; tick(1);
    chk("t1 state DONE", 32'(if1.outState), 3);
    chk("t1 cpuHold in DONE", 32'(if1.cpuHold), 1);
    finish_r = 1'b0; tick(1);
    chk("t1 state IDLE", 32'(if1.outState), 0);
    chk("t1 cpuHold released", 32'(if1.cpuHold), 0);
    chk("t1 outDone one cycle", 32'(if1.outDone), 0);

    // 2: two words ABCD, 000F
    start_pulse();
    push_w(0, 16'hABCD); push_w(1, 16'h000F);
    nib(4'hA); nib(4'hB); nib(4'hC); nib(4'hD);
    nib(4'h0); nib(4'h0); nib(4'h0); nib(4'hF);
    push_d(2, 0);
    fin_pulse();
    chk("t2 cpuHold released", 32'(if1.cpuHold), 0);

    // 3: partial word discarded; last nibble arrives together with finish
    start_pulse();
    nib(4'h1);
    push_d(0, 0);
    in_r = 4'h2; strobe_r = 1'b1; finish_r = 1'b1; tick(1);
    chk("t3 state DONE", 32'(if1.outState), 3);
    strobe_r = 1'b0; finish_r = 1'b0; tick(1);
    chk("t3 state IDLE", 32'(if1.outState), 0);
    chk("t3 wordCount", 32'(if1.wordCount), 0);

    // 4: next word follows immediately; then completing nibble with finish
    start_pulse();
    push_w(0, 16'h1234); push_w(1, 16'h789A); push_w(2, 16'hBCDE);
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    nib(4'h7); nib(4'h8); nib(4'h9); nib(4'hA);
    nib(4'hB); nib(4'hC); nib(4'hD);
    push_d(3, 0);
    in_r = 4'hE; strobe_r = 1'b1; finish_r = 1'b1; tick(1);
    chk("t4 state WRITE", 32'(if1.outState), 2);
    chk("t4 imWren", 32'(if1.imWren), 1);
    strobe_r = 1'b0; finish_r = 1'b0; tick(1);
    chk("t4 state DONE", 32'(if1.outState), 3);
    tick(1);
    chk("t4 state IDLE", 32'(if1.outState), 0);

    // 5: full memory on the ADDR_WIDTH=2 instance
    sel = 1;
    start_pulse();
    push_w(0, 16'h1111); push_w(1, 16'h2222); push_w(2, 16'h3333); push_w(3, 16'h4444);
    for (int unsigned k = 1; k <= 4; k++) begin
      nib(4'(k)); nib(4'(k)); nib(4'(k)); nib(4'(k));
    end
    chk("t5 wordCount full", 32'(if2.wordCount), 4);
    chk("t5 address wrapped", 32'(if2.imAddress), 0);
    chk("t5 overflow clear", 32'(if2.overflow), 0);
    nib(4'h5);
    chk("t5 overflow set", 32'(if2.overflow), 1);
    nib(4'h6); nib(4'h7); nib(4'h8);
    chk("t5 wordCount stays", 32'(if2.wordCount), 4);
    chk("t5 cpuHold open", 32'(if2.cpuHold), 1);
    push_d(4, 1);
    fin_pulse();
    chk("t5 overflow held in IDLE", 32'(if2.overflow), 1);
    start_pulse();
    chk("t5 overflow cleared", 32'(if2.overflow), 0);
    chk("t5 wordCount cleared", 32'(if2.wordCount), 0);
    push_d(0, 0);
    fin_pulse();
    sel = 0;

    // 6: reset mid-session, then strobe held high through reset
    start_pulse();
    nib(4'h1); nib(4'h2);
    reset = 1'b1; tick(1);
    chk("t6 state IDLE", 32'(if1.outState), 0);
    chk("t6 imWren", 32'(if1.imWren), 0);
    chk("t6 cpuHold", 32'(if1.cpuHold), 0);
    strobe_r = 1'b1; in_r = 4'hF; tick(1);
    reset = 1'b0; tick(2);
    start_pulse();
    strobe_r = 1'b0; tick(1);
    push_w(0, 16'h1234);
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    push_d(1, 0);
    fin_pulse();
    tick(2);

    chk("dut1 writes drained", wq1.size(), 0);
    chk("dut1 dones drained", dq1.size(), 0);
    chk("dut2 writes drained", wq2.size(), 0);
    chk("dut2 dones drained", dq2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
